// File: rtl/cbrt_dispatcher.sv
// cbrt_dispatcher
//   Stream front-end for the cube-root unit. Operands arrive on a valid/ready
//   input stream and are buffered in a small FIFO. They are issued one at a
//   time to the cube-root unit over its start/busy handshake, and each root is
//   returned with its operand on a valid/ready output stream. A watchdog
//   aborts an operation whose cube-root unit stays busy too long; that result
//   is returned with out_err=1 and out_data=0.
//
// Ports
//   clk, rst          system clock (rising edge); async active-high reset
//   in_valid/ready    operand stream handshake (in_ready = FIFO not full)
//   in_data           8-bit operand
//   out_valid/ready   result stream handshake
//   out_data          3-bit floor cube root, 0 on watchdog abort
//   out_x             operand that produced out_data
//   out_err           result was aborted by the watchdog
//   done_count        results handed off, wraps at 256
//   cbrt_x            operand to the cube-root unit
//   cbrt_start        one-cycle start pulse to the cube-root unit
//   cbrt_busy         cube-root unit busy
//   cbrt_result       cube-root unit result
//
// States
//   IDLE  | waiting for an operand; pops the FIFO head into x_reg
//   ISSUE | cbrt_start asserted for this single cycle; watchdog cleared
//   WAIT  | waiting for busy to drop, or for the watchdog to expire
//   OUT   | result held on the output stream until accepted

module cbrt_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_data,
  output logic [7:0] out_x,
  output logic       out_err,
  output logic [7:0] done_count,
  output logic [7:0] cbrt_x,
  output logic       cbrt_start,
  input  logic       cbrt_busy,
  input  logic [2:0] cbrt_result
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      x_reg;
  logic [TW-1:0]   timer;
  logic            push, pop, empty, full;
  logic            timer_expired;

  assign empty         = (count == '0);
  assign full          = (count == CW'(FIFO_DEPTH));
  assign in_ready      = !full;
  assign push          = in_valid && in_ready;
  assign pop           = (state == IDLE) && !empty;
  assign timer_expired = (timer == TIMER_LAST);
  assign cbrt_x        = x_reg;
  assign cbrt_start    = (state == ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (!cbrt_busy || timer_expired) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg      <= '0;
      timer      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_x      <= '0;
      out_err    <= 1'b0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) x_reg <= mem[rd_ptr];
        end
        ISSUE: begin
          timer <= '0;
        end
        WAIT: begin
          if (!cbrt_busy) begin
            out_data  <= cbrt_result;
            out_x     <= x_reg;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
          end else if (timer_expired) begin
            out_data  <= '0;
            out_x     <= x_reg;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            done_count <= done_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cbrt_dispatcher.sv
module tb_cbrt_dispatcher;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] out_data;
  logic [7:0] out_x;
  logic       out_err;
  logic [7:0] done_count;
  logic [7:0] cbrt_x;
  logic       cbrt_start;
  logic       cbrt_busy;
  logic [2:0] cbrt_result;

  int compared = 0;
  int mismatched = 0;

  cbrt_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_err(out_err), .done_count(done_count),
    .cbrt_x(cbrt_x), .cbrt_start(cbrt_start), .cbrt_busy(cbrt_busy),
    .cbrt_result(cbrt_result)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] cube_root(input logic [7:0] x);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 7; i++)
      if (i * i * i <= int'(x)) r = 3'(i);
    return r;
  endfunction

  // Cube-root unit stub: busy for lat cycles after sampling start; in hang
  // mode busy never drops.
  int         lat = 3;
  logic       hang = 1'b0;
  int         stub_cnt;
  logic       stub_busy;
  logic [2:0] stub_res;
  assign cbrt_busy   = stub_busy;
  assign cbrt_result = stub_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else if (cbrt_start && !stub_busy) begin
      stub_busy <= 1'b1;
      stub_cnt  <= lat - 1;
      stub_res  <= cube_root(cbrt_x);
    end else if (stub_busy && !hang) begin
      if (stub_cnt == 0) stub_busy <= 1'b0;
      else               stub_cnt  <= stub_cnt - 1;
    end
  end

  // Scoreboard: expectations recorded when an input handshake is seen,
  // checked when an output handshake is seen.
  typedef struct {
    logic [7:0] x;
    logic [2:0] d;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] issue_q[$];
  int         accepted_cnt = 0;
  int         start_cnt = 0;
  logic [7:0] exp_done = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.x   = in_data;
        e.d   = hang ? 3'd0 : cube_root(in_data);
        e.err = hang;
        sb.push_back(e);
        issue_q.push_back(in_data);
        accepted_cnt++;
      end
      if (cbrt_start) begin
        start_cnt++;
        compared++;
        if (issue_q.size() == 0) begin
          mismatched++;
          $display("FAIL issue_unexpected: cbrt_x=%0d with no operand pending", cbrt_x);
        end else begin
          logic [7:0] ex;
          ex = issue_q.pop_front();
          if (cbrt_x !== ex || cbrt_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL issue: cbrt_x=%0d busy=%b, required cbrt_x=%0d busy=0",
                     cbrt_x, cbrt_busy, ex);
          end
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL out_unexpected: out_x=%0d out_data=%0d with nothing pending",
                   out_x, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_x !== e.x || out_data !== e.d || out_err !== e.err || done_count !== exp_done) begin
            mismatched++;
            $display("FAIL handoff: got x=%0d d=%0d err=%b cnt=%0d, required x=%0d d=%0d err=%b cnt=%0d",
                     out_x, out_data, out_err, done_count, e.x, e.d, e.err, exp_done);
          end
        end
        exp_done = exp_done + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    issue_q.delete();
    exp_done = '0;
    start_cnt = 0;
    accepted_cnt = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    hang = 1'b0;
    lat = 3;
    rst = 1'b1;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_wait(input logic [7:0] x);
    logic acc;
    in_valid = 1'b1;
    in_data = x;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    compared++;
    if (!acc) begin
      mismatched++;
      $display("FAIL push_timeout: operand %0d never accepted", x);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    tick();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d results outstanding after %0d cycles", name, sb.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 3'd0 || out_x !== 8'd0 ||
        out_err !== 1'b0 || done_count !== 8'd0 || cbrt_x !== 8'd0 || cbrt_start !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d out_x=%0d err=%b cnt=%0d cbrt_x=%0d start=%b, required 1 0 0 0 0 0 0 0",
               in_ready, out_valid, out_data, out_x, out_err, done_count, cbrt_x, cbrt_start);
    end
    do_reset();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    out_ready = 1'b1;
    push_wait(8'd27);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    // pop edge, ISSUE->WAIT edge, lat busy WAIT cycles, capture edge
    compared++;
    if (n != lat + 3) begin
      mismatched++;
      $display("FAIL single_latency: out_valid after %0d cycles, required %0d", n, lat + 3);
    end
    wait_drain("single");
    compared++;
    if (start_cnt != 1 || done_count !== 8'd1) begin
      mismatched++;
      $display("FAIL single_counts: starts=%0d done_count=%0d, required 1 and 1", start_cnt, done_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v[4] = '{8'd8, 8'd64, 8'd125, 8'd216};
    logic       dropped;
    do_reset();
    out_ready = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = v[i];
      if (!in_ready) dropped = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    compared++;
    if (dropped || accepted_cnt != 4) begin
      mismatched++;
      $display("FAIL b2b_accept: in_ready dropped=%b accepted=%0d, required 0 and 4", dropped, accepted_cnt);
    end
    wait_drain("b2b");
    compared++;
    if (done_count !== 8'd4) begin
      mismatched++;
      $display("FAIL b2b_done_count: got %0d, required 4", done_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] v[10] = '{8'd8, 8'd64, 8'd125, 8'd216, 8'd27, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic       held;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = v[i];
      tick();
    end
    in_valid = 1'b0;
    compared++;
    if (accepted_cnt != 5 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 5 and 0", accepted_cnt, in_ready);
    end
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b1 || out_data !== 3'd2 || out_x !== 8'd8 || out_err !== 1'b0) held = 1'b0;
      tick();
    end
    compared++;
    if (!held) begin
      mismatched++;
      $display("FAIL bp_hold: out_valid=%b out_data=%0d out_x=%0d, required 1 2 8 stable", out_valid, out_data, out_x);
    end
    out_ready = 1'b1;
    wait_drain("bp");
    compared++;
    if (done_count !== 8'd5) begin
      mismatched++;
      $display("FAIL bp_done_count: got %0d, required 5", done_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    out_ready = 1'b1;
    hang = 1'b1;
    push_wait(8'd100);
    n = 0;
    while (!cbrt_start && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    // one ISSUE->WAIT edge plus TMO WAIT cycles
    compared++;
    if (n != TMO + 1 || out_err !== 1'b1 || out_data !== 3'd0 || out_x !== 8'd100) begin
      mismatched++;
      $display("FAIL timeout: after %0d cycles err=%b data=%0d x=%0d, required %0d cycles err=1 data=0 x=100",
               n, out_err, out_data, out_x, TMO + 1);
    end
    wait_drain("timeout");
    hang = 1'b0;
    n = 0;
    while (cbrt_busy && n < 50) begin
      tick();
      n++;
    end
    push_wait(8'd64);
    wait_drain("after_timeout");
    compared++;
    if (done_count !== 8'd2 || start_cnt != 2) begin
      mismatched++;
      $display("FAIL after_timeout: done_count=%0d starts=%0d, required 2 and 2", done_count, start_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    out_ready = 1'b1;
    lat = 40;
    for (int i = 0; i < 4; i++) push_wait(8'(10 + i));
    tick();
    tick();
    compared++;
    if (dut.state !== 2'd2) begin
      mismatched++;
      $display("FAIL midop_setup: not in WAIT before reset (state=%0d)", dut.state);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (out_valid !== 1'b0 || cbrt_start !== 1'b0 || in_ready !== 1'b1 || cbrt_x !== 8'd0) begin
      mismatched++;
      $display("FAIL midop_reset: out_valid=%b start=%b in_ready=%b cbrt_x=%0d, required 0 0 1 0",
               out_valid, cbrt_start, in_ready, cbrt_x);
    end
    clear_model();
    lat = 3;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    compared++;
    if (start_cnt != 0 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL midop_stale: starts=%0d out_valid=%b after reset, required 0 and 0", start_cnt, out_valid);
    end
    push_wait(8'd0);
    wait_drain("midop");
    compared++;
    if (done_count !== 8'd1) begin
      mismatched++;
      $display("FAIL midop_done_count: got %0d, required 1", done_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    lat = 1;
    push_wait(8'd0);
    push_wait(8'd255);
    wait_drain("edges");
    for (int i = 2; i < 256; i++) push_wait(8'($urandom_range(0, 255)));
    wait_drain("wrap");
    compared++;
    if (done_count !== 8'd0 || exp_done !== 8'd0) begin
      mismatched++;
      $display("FAIL wrap: done_count=%0d model=%0d, required 0", done_count, exp_done);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cbrt_dispatcher.md
Name: cbrt_dispatcher

Overview:
- Stream front-end for the cube-root unit. Accepts 8-bit operands on a valid/ready input stream and buffers them in a small FIFO.
- Issues them one at a time to the cube-root unit over its start/busy interface. Returns each 3-bit root, tagged with its operand, on a valid/ready output stream.
- Sits directly upstream of the cube-root unit and drives its x_i/start. Consumes its result/busy.
- Adds a watchdog so a hung cube-root unit cannot stall the stream.

Parameters:
- FIFO_DEPTH, 4, input FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 2000, maximum WAIT cycles before an operation is aborted with an error.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset. Shared with the cube-root unit.
- in_valid  input  1  operand available.
- in_ready  output  1  FIFO can accept; equals !full.
- in_data  input  8  operand.
- out_valid  output  1  result held for consumer.
- out_ready  input  1  consumer accepts result.
- out_data  output  3  cube root (floor); 0 on error.
- out_x  output  8  operand that produced out_data.
- out_err  output  1  result aborted by watchdog.
- done_count  output  8  number of results handed off; wraps.
- cbrt_x  output  8  operand to cube-root unit x_i.
- cbrt_start  output  1  one-cycle start pulse.
- cbrt_busy  input  1  cube-root unit busy.
- cbrt_result  input  3  cube-root unit result.

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst:
  - FIFO empty, so in_ready=1.
  - out_valid=0, out_data=0, out_x=0, out_err=0, done_count=0.
  - cbrt_x=0, cbrt_start=0, state=IDLE, watchdog timer=0.
- Reset mid-operation aborts everything:
  - Queued and in-flight operands are discarded and no result is emitted.
  - Normal operation resumes on the first clk edge after rst deasserts.
- FIFO:
  - Push on in_valid&&in_ready. Pop only in IDLE when not empty.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle: count unchanged.
  - When full, in_ready=0 and there is no same-cycle bypass.
  - Order is strictly FIFO.
- State machine:
  - IDLE: if FIFO not empty, pop head into x_reg and go to ISSUE; else stay.
  - ISSUE: cbrt_start=1 for exactly this cycle; timer cleared; go to WAIT.
  - WAIT:
    - The cube-root unit raises busy in the cycle after it samples start, so the first WAIT cycle sees busy=1.
    - If cbrt_busy=0: capture out_data=cbrt_result, out_x=x_reg, out_err=0, set out_valid=1, go to OUT.
    - Else if timer==TIMEOUT_CYCLES-1: out_data=0, out_x=x_reg, out_err=1, out_valid=1, go to OUT.
    - Else increment the timer.
  - OUT: hold all out_* stable while out_valid&&!out_ready. On out_ready: out_valid=0, done_count+1 (255 wraps to 0), go to IDLE.
- cbrt_x is driven from x_reg. It is stable from ISSUE through the end of WAIT and changes only on a pop.
- cbrt_start is never asserted outside ISSUE, and never while cbrt_busy=1.
- Latency and throughput:
  - From a push into an empty FIFO in IDLE: 1 cycle to pop, 1 ISSUE cycle, then N busy cycles, then out_valid.
  - With out_ready=1, the next operand is issued 2 cycles after the handoff (OUT→IDLE→ISSUE).
- Input acceptance continues in every state while the FIFO is not full.

Test Plan:
- rst pulse, then push 27 with out_ready=1: exactly one cbrt_start pulse with cbrt_x=27; then out_valid=1, out_data=3, out_x=27, out_err=0, done_count=1.
- Push 8, 64, 125, 216 on consecutive cycles with out_ready=1: in_ready stays 1; outputs in order 2/8, 4/64, 5/125, 6/216, each with out_err=0; done_count=4.
- out_ready=0, push 10 operands continuously: exactly 5 accepted (1 in flight plus 4 queued), in_ready=0 afterwards.
  - Outputs hold 2/8 unchanged for 20 cycles.
  - Then out_ready=1 drains the remaining 4 in order.
- Bench stub holds cbrt_busy=1, TIMEOUT_CYCLES=16, push 100: out_valid rises after 16 WAIT cycles with out_err=1, out_data=0, out_x=100. The next operand is then issued normally.
- Assert rst during WAIT with 3 operands queued: out_valid=0, cbrt_start=0, in_ready=1 immediately. After release no stale result appears, and the next push of 0 yields out_data=0, out_err=0.
- Push 0 then 255: out_data 0 then 6. 256 handoffs wrap done_count back to 0.
